// File: rtl/score_digits_pkg.sv
// Shared constants, FSM encodings and helpers for the score_digits converter.
// Optional build macro: SCORE_LZ_BLANK_EN (blank leading zero digits).
package score_digits_pkg;

    localparam int NUM_W  = 12;
    localparam int DIG_N  = 4;
    localparam int NIB_W  = 4;
    localparam int BCD_W  = NIB_W * DIG_N;
    localparam int ITER_W = 4;

    localparam logic [ITER_W-1:0] ITER_N    = 4'd12;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_N - 4'd1;

    localparam logic [NIB_W-1:0] CHAR_BLANK = 4'hF;
    localparam logic [NIB_W-1:0] ADJ_MIN    = 4'd5;
    localparam logic [NIB_W-1:0] ADJ_ADD    = 4'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Replace leading zero digits with CHAR_BLANK; the ones digit always stays.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        if (bcd[15:12] == 4'd0) begin
            res[15:12] = CHAR_BLANK;
            if (bcd[11:8] == 4'd0) begin
                res[11:8] = CHAR_BLANK;
                if (bcd[7:4] == 4'd0) begin
                    res[7:4] = CHAR_BLANK;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_digits_bcd_adj3.sv
// One double-dabble nibble correction: digits of 5 or more get +3 before the shift.
module bcd_adj3
    import score_digits_pkg::*;
(
    input  logic [NIB_W-1:0] din,
    output logic [NIB_W-1:0] dout
);

    assign dout = (din >= ADJ_MIN) ? din + ADJ_ADD : din;

endmodule

// File: rtl/score_digits.sv
// Sequential 12-bit binary to 4-digit BCD converter (shift-and-add-3).
// Build macro SCORE_LZ_BLANK_EN blanks leading zero digits with CHAR_BLANK.
module score_digits
    import score_digits_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] number,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [NIB_W-1:0] char0,
    output logic [NIB_W-1:0] char1,
    output logic [NIB_W-1:0] char2,
    output logic [NIB_W-1:0] char3
);

    // Handshake: start is a one-cycle request honoured only in IDLE (busy low or
    // done high); busy covers the 13 cycles of work; done pulses once when the
    // char outputs change. Requests while busy are dropped, never queued.

    logic [1:0]        state;
    logic [NUM_W-1:0]  bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  disp;
    logic [ITER_W-1:0] iter_q;

    for (genvar g = 0; g < DIG_N; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (bcd_q[g*NIB_W +: NIB_W]),
            .dout (bcd_adj[g*NIB_W +: NIB_W])
        );
    end

`ifdef SCORE_LZ_BLANK_EN
    assign disp = blank_leading(bcd_q);
`else
    assign disp = bcd_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            char0  <= '0;
            char1  <= '0;
            char2  <= '0;
            char3  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_q  <= number;
                        bcd_q  <= '0;
                        iter_q <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Corrected digits and remaining binary shift as one word.
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    iter_q         <= iter_q + 4'd1;
                    if (iter_q == ITER_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    char0 <= disp[15:12];
                    char1 <= disp[11:8];
                    char2 <= disp[7:4];
                    char3 <= disp[3:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_digits.sv
// Self-checking bench for score_digits; honours SCORE_LZ_BLANK_EN when defined.
module tb_score_digits;

    logic        clk;
    logic        rst;
    logic [11:0] number;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  char0, char1, char2, char3;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    score_digits dut (
        .clk    (clk),
        .rst    (rst),
        .number (number),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .char0  (char0),
        .char1  (char1),
        .char2  (char2),
        .char3  (char3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int n);
        logic [3:0] d0, d1, d2, d3;
        d0 = 4'(n / 1000);
        d1 = 4'((n / 100) % 10);
        d2 = 4'((n / 10) % 10);
        d3 = 4'(n % 10);
`ifdef SCORE_LZ_BLANK_EN
        if (d0 == 4'd0) begin
            d0 = 4'hF;
            if (d1 == 4'd0) begin
                d1 = 4'hF;
                if (d2 == 4'd0) d2 = 4'hF;
            end
        end
`endif
        return {d0, d1, d2, d3};
    endfunction

    // scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("chars", {16'd0, char0, char1, char2, char3}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // driver: one conversion with timing checks; optional disturbance mid-run
    task automatic conv_timed(input int num, input bit disturb);
        int busy_cnt;
        int done_cnt;
        int done_at;
        @(negedge clk);
        number = 12'(num);
        start  = 1'b1;
        exp_q.push_back(model(num));
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (disturb && i == 4) begin
                number = 12'd999;
                start  = 1'b1;
            end else if (disturb && i == 5) begin
                number = 12'd555;
                start  = 1'b0;
            end
            if (i < 19) @(negedge clk);
        end
        check("busy_cycles", busy_cnt, 32'd13);
        check("done_latency", done_at, 32'd13);
        check("done_count", done_cnt, 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, {26'd0, busy, done, char0, char1, char2, char3}, 32'd0);
    endtask

    initial begin
        logic [15:0] hold_val;
        int gap;
        bit found;
        rst    = 1'b0;
        start  = 1'b0;
        number = 12'd0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_state");
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("after_release");

        conv_timed(1234, 1'b0);
        conv_timed(4095, 1'b0);
        conv_timed(0, 1'b0);
        conv_timed(50, 1'b0);
        conv_timed(1005, 1'b0);
        conv_timed(7, 1'b0);

        // second start and number change mid-run are ignored
        conv_timed(321, 1'b1);
        check("hold_321", {16'd0, char0, char1, char2, char3}, {16'd0, model(321)});

        // reset mid-conversion
        @(negedge clk);
        number = 12'd777;
        start  = 1'b1;
        exp_q.push_back(model(777));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_zero_outputs("rst_mid_immediate");
        @(negedge clk);
        check_zero_outputs("rst_mid_held");
        rst = 1'b1;
        conv_timed(42, 1'b0);

        // back-to-back: second start lands in the done cycle
        @(negedge clk);
        number = 12'd100;
        start  = 1'b1;
        exp_q.push_back(model(100));
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (done) found = 1'b1;
            else @(negedge clk);
        end
        check("b2b_first_done", {31'd0, found}, 32'd1);
        hold_val = model(100);
        number = 12'd200;
        start  = 1'b1;
        exp_q.push_back(model(200));
        @(negedge clk);
        start = 1'b0;
        gap   = 1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (done) begin
                found = 1'b1;
            end else begin
                if (gap == 7) check("b2b_hold", {16'd0, char0, char1, char2, char3}, {16'd0, hold_val});
                gap++;
                @(negedge clk);
            end
        end
        check("b2b_gap", gap, 32'd14);

        // random stimulus
        for (int r = 0; r < 6; r++) begin
            conv_timed(int'($urandom_range(0, 4095)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
